pifo_flow_sched: RTL and testbench

Flow-level PIFO scheduler with integrated sorted register storage, per-flow backlog tracking and automatic rank-advanced re-enqueue. It sits between the packet classifier, which reports flow arrivals and flow-empty events, and the dispatch stage, which consumes flow IDs in priority order. It tracks per-flow state, suppresses duplicate entries, re-inserts a still-backlogged flow when its dequeue is accepted, and evicts the worst-ranked entry on overflow.

---
 rtl/pifo_flow_sched.sv | 167 ++++++++++++++++
 tb/tb_pifo_flow_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_flow_sched.sv
// pifo_flow_sched: flow-level PIFO scheduler with a shift-register sorted
// array, per-flow active/queued tracking and rank-advanced re-enqueue.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready/in_flow/in_prio  flow arrival handshake
//   empty_valid/empty_flow             flow-drained notification
//   cfg_quantum                        rank increment applied on re-enqueue
//   out_valid/out_ready/out_flow/out_prio  registered head entry
//   drop_valid/drop_flow/drop_prio     one-cycle eviction/reject pulse
//   occupancy                          valid entries in the sorted array
module pifo_flow_sched #(
  parameter int NUM_FLOWS = 64,
  parameter int DEPTH     = 16,
  parameter int BITPRIO   = 16,
  parameter int BITFLOW   = $clog2(NUM_FLOWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITFLOW-1:0]         in_flow,
  input  logic [BITPRIO-1:0]         in_prio,
  input  logic                       empty_valid,
  input  logic [BITFLOW-1:0]         empty_flow,
  input  logic [BITPRIO-1:0]         cfg_quantum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITFLOW-1:0]         out_flow,
  output logic [BITPRIO-1:0]         out_prio,
  output logic                       drop_valid,
  output logic [BITFLOW-1:0]         drop_flow,
  output logic [BITPRIO-1:0]         drop_prio,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCCW = $clog2(DEPTH + 1);

  logic [NUM_FLOWS-1:0] active, queued, active_nxt, queued_nxt;
  logic [DEPTH-1:0]     slot_valid, post_valid, le, nxt_valid;
  logic [BITFLOW-1:0]   slot_flow [DEPTH];
  logic [BITPRIO-1:0]   slot_prio [DEPTH];
  logic [BITFLOW-1:0]   post_flow [DEPTH];
  logic [BITPRIO-1:0]   post_prio [DEPTH];
  logic [BITFLOW-1:0]   nxt_flow  [DEPTH];
  logic [BITPRIO-1:0]   nxt_prio  [DEPTH];

  logic               hs, reenq, arr_acc, ins, pop, full, ovf, evict, do_ins;
  logic [BITFLOW-1:0] ins_flow, drop_f;
  logic [BITPRIO-1:0] ins_prio, sat_prio, drop_p;
  logic [BITPRIO:0]   sum;

  assign hs       = out_valid && out_ready;
  assign reenq    = hs && active[out_flow] && !(empty_valid && empty_flow == out_flow);
  assign in_ready = !reenq;
  assign arr_acc  = in_valid && in_ready;
  assign sum      = {1'b0, out_prio} + {1'b0, cfg_quantum};
  assign sat_prio = sum[BITPRIO] ? '1 : sum[BITPRIO-1:0];
  assign ins      = reenq || (arr_acc && !queued[in_flow]);
  assign ins_flow = reenq ? out_flow : in_flow;
  assign ins_prio = reenq ? sat_prio : in_prio;
  assign pop      = slot_valid[0] && (!out_valid || out_ready);
  assign full     = (occupancy == OCCW'(DEPTH));

  always_comb begin
    // View of the array after this cycle's pop; the insert is placed
    // relative to these contents.
    post_valid = slot_valid;
    post_flow  = slot_flow;
    post_prio  = slot_prio;
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        post_valid[i] = slot_valid[i+1];
        post_flow[i]  = slot_flow[i+1];
        post_prio[i]  = slot_prio[i+1];
      end
      post_valid[DEPTH-1] = 1'b0;
      post_flow[DEPTH-1]  = '0;
      post_prio[DEPTH-1]  = '0;
    end

    ovf    = ins && full && !pop;
    evict  = ovf && (ins_prio < post_prio[DEPTH-1]);
    do_ins = ins && !(ovf && !evict);
    drop_f = evict ? post_flow[DEPTH-1] : ins_flow;
    drop_p = evict ? post_prio[DEPTH-1] : ins_prio;

    // le is a contiguous prefix since the array is sorted; the new entry
    // lands just past it and everything behind shifts down one slot
    // (on eviction the old tail falls off the end).
    for (int unsigned i = 0; i < DEPTH; i++)
      le[i] = post_valid[i] && (post_prio[i] <= ins_prio);

    nxt_valid = post_valid;
    nxt_flow  = post_flow;
    nxt_prio  = post_prio;
    if (do_ins) begin
      if (!le[0]) begin
        nxt_valid[0] = 1'b1;
        nxt_flow[0]  = ins_flow;
        nxt_prio[0]  = ins_prio;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (!le[i]) begin
          if (le[i-1]) begin
            nxt_valid[i] = 1'b1;
            nxt_flow[i]  = ins_flow;
            nxt_prio[i]  = ins_prio;
          end else begin
            nxt_valid[i] = post_valid[i-1];
            nxt_flow[i]  = post_flow[i-1];
            nxt_prio[i]  = post_prio[i-1];
          end
        end
      end
    end

    // Arrival beats a same-cycle empty event for the same flow.
    active_nxt = active;
    if (empty_valid) active_nxt[empty_flow] = 1'b0;
    if (arr_acc)     active_nxt[in_flow]    = 1'b1;

    queued_nxt = queued;
    if (hs)     queued_nxt[out_flow] = 1'b0;
    if (do_ins) queued_nxt[ins_flow] = 1'b1;
    if (ovf)    queued_nxt[drop_f]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      queued     <= '0;
      slot_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_flow[i] <= '0;
        slot_prio[i] <= '0;
      end
      out_valid  <= 1'b0;
      out_flow   <= '0;
      out_prio   <= '0;
      drop_valid <= 1'b0;
      drop_flow  <= '0;
      drop_prio  <= '0;
      occupancy  <= '0;
    end else begin
      active     <= active_nxt;
      queued     <= queued_nxt;
      slot_valid <= nxt_valid;
      slot_flow  <= nxt_flow;
      slot_prio  <= nxt_prio;
      occupancy  <= occupancy + OCCW'(do_ins && !evict) - OCCW'(pop);
      drop_valid <= ovf;
      if (ovf) begin
        drop_flow <= drop_f;
        drop_prio <= drop_p;
      end
      if (pop) begin
        out_valid <= 1'b1;
        out_flow  <= slot_flow[0];
        out_prio  <= slot_prio[0];
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pifo_flow_sched.sv
// Directed self-checking bench for pifo_flow_sched.
module tb_pifo_flow_sched;

  localparam int NUM_FLOWS = 64;
  localparam int DEPTH     = 16;
  localparam int BITPRIO   = 16;
  localparam int BITFLOW   = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready;
  logic [BITFLOW-1:0] in_flow;
  logic [BITPRIO-1:0] in_prio;
  logic               empty_valid;
  logic [BITFLOW-1:0] empty_flow;
  logic [BITPRIO-1:0] cfg_quantum;
  logic               out_valid, out_ready;
  logic [BITFLOW-1:0] out_flow;
  logic [BITPRIO-1:0] out_prio;
  logic               drop_valid;
  logic [BITFLOW-1:0] drop_flow;
  logic [BITPRIO-1:0] drop_prio;
  logic [4:0]         occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pifo_flow_sched #(
    .NUM_FLOWS(NUM_FLOWS),
    .DEPTH(DEPTH),
    .BITPRIO(BITPRIO),
    .BITFLOW(BITFLOW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flow(in_flow), .in_prio(in_prio),
    .empty_valid(empty_valid), .empty_flow(empty_flow), .cfg_quantum(cfg_quantum),
    .out_valid(out_valid), .out_ready(out_ready), .out_flow(out_flow), .out_prio(out_prio),
    .drop_valid(drop_valid), .drop_flow(drop_flow), .drop_prio(drop_prio),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input int f, input int p);
    in_valid = 1'b1;
    in_flow  = BITFLOW'(f);
    in_prio  = BITPRIO'(p);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_evt(input int f);
    empty_valid = 1'b1;
    empty_flow  = BITFLOW'(f);
    tick();
    empty_valid = 1'b0;
  endtask

  task automatic run_basic(input string pfx);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_flow   = 6'd5;
    in_prio   = 16'd10;
    #1;
    check({pfx, "_c0_in_ready"}, in_ready, 1);
    check({pfx, "_c0_occ"}, occupancy, 0);
    tick();
    in_valid = 1'b0;
    check({pfx, "_c1_occ"}, occupancy, 1);
    check({pfx, "_c1_out_valid"}, out_valid, 0);
    empty_valid = 1'b1;
    empty_flow  = 6'd5;
    tick();
    empty_valid = 1'b0;
    check({pfx, "_c2_out_valid"}, out_valid, 1);
    check({pfx, "_c2_out_flow"}, out_flow, 5);
    check({pfx, "_c2_out_prio"}, out_prio, 10);
    check({pfx, "_c2_occ"}, occupancy, 0);
    check({pfx, "_c2_in_ready"}, in_ready, 1);
    tick();
    check({pfx, "_c3_out_valid"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int exp_f[5];
    int exp_p[5];
    exp_f = '{9, 2, 4, 1, 3};
    exp_p = '{0, 10, 10, 30, 30};

    rst_n = 1'b0; in_valid = 1'b0; in_flow = '0; in_prio = '0;
    empty_valid = 1'b0; empty_flow = '0; cfg_quantum = 16'd50; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_drop_valid", drop_valid, 0);
    check("rst_out_flow", out_flow, 0);
    check("rst_out_prio", out_prio, 0);
    rst_n = 1'b1;
    tick();

    run_basic("basic");

    // Ordering: park flow 9 in the output register, then four arrivals.
    arrive(9, 0);
    drain_evt(9);
    check("ord_park_valid", out_valid, 1);
    check("ord_park_flow", out_flow, 9);
    arrive(1, 30); arrive(2, 10); arrive(3, 30); arrive(4, 10);
    drain_evt(1); drain_evt(2); drain_evt(3); drain_evt(4);
    check("ord_occ4", occupancy, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ord_valid_%0d", k), out_valid, 1);
      check($sformatf("ord_flow_%0d", k), out_flow, exp_f[k]);
      check($sformatf("ord_prio_%0d", k), out_prio, exp_p[k]);
      tick();
    end
    check("ord_end_valid", out_valid, 0);
    check("ord_end_occ", occupancy, 0);
    out_ready = 1'b0;

    // Re-enqueue with quantum 50.
    arrive(7, 100);
    tick();
    check("rq_head_flow", out_flow, 7);
    out_ready = 1'b1;
    #1;
    check("rq_in_ready_low", in_ready, 0);
    tick();
    out_ready = 1'b0;
    check("rq_occ_after_hs", occupancy, 1);
    check("rq_out_valid_gap", out_valid, 0);
    tick();
    check("rq_out_valid", out_valid, 1);
    check("rq_out_flow", out_flow, 7);
    check("rq_out_prio", out_prio, 150);
    // Empty event in the handshake cycle suppresses the re-insert.
    out_ready = 1'b1; empty_valid = 1'b1; empty_flow = 6'd7;
    #1;
    check("noreq_in_ready", in_ready, 1);
    tick();
    empty_valid = 1'b0; out_ready = 1'b0;
    check("noreq_occ", occupancy, 0);
    tick();
    check("noreq_out_valid", out_valid, 0);
    check("noreq_occ2", occupancy, 0);

    // Saturating re-enqueue.
    arrive(7, 65500);
    tick();
    check("sat_head_prio", out_prio, 65500);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("sat_out_valid", out_valid, 1);
    check("sat_out_flow", out_flow, 7);
    check("sat_out_prio", out_prio, 65535);
    out_ready = 1'b1; empty_valid = 1'b1; empty_flow = 6'd7;
    tick();
    empty_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("sat_clean_valid", out_valid, 0);

    // Duplicate arrivals.
    arrive(20, 5);
    arrive(20, 5);
    check("dup_occ0", occupancy, 0);
    check("dup_head", out_flow, 20);
    arrive(21, 6);
    arrive(21, 6);
    check("dup_occ1", occupancy, 1);
    drain_evt(20); drain_evt(21);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("dup_clean_valid", out_valid, 0);
    check("dup_clean_occ", occupancy, 0);

    // Overflow: output register holds flow 50, array holds flows 10..25 at prio 0..15.
    arrive(50, 0);
    for (int i = 0; i < DEPTH; i++) arrive(10 + i, i);
    check("ovf_full_occ", occupancy, 16);
    check("ovf_head", out_flow, 50);
    check("ovf_no_drop_yet", drop_valid, 0);
    arrive(40, 3);
    check("ovf_evict_valid", drop_valid, 1);
    check("ovf_evict_flow", drop_flow, 25);
    check("ovf_evict_prio", drop_prio, 15);
    check("ovf_evict_occ", occupancy, 16);
    tick();
    check("ovf_pulse_one", drop_valid, 0);
    arrive(41, 20);
    check("ovf_rej_valid", drop_valid, 1);
    check("ovf_rej_flow", drop_flow, 41);
    check("ovf_rej_prio", drop_prio, 20);
    // Flow 25 was evicted, so it is no longer queued and inserts again.
    arrive(25, 1);
    check("ovf_reins_valid", drop_valid, 1);
    check("ovf_reins_flow", drop_flow, 24);
    check("ovf_reins_prio", drop_prio, 14);

    // Mid-operation reset.
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_flow", out_flow, 0);
    check("mrst_out_prio", out_prio, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_occ", occupancy, 0);
    check("mrst_drop_valid", drop_valid, 0);
    check("mrst_drop_flow", drop_flow, 0);
    tick();
    tick();
    check("mrst_drop_hold", drop_valid, 0);
    rst_n = 1'b1;
    tick();
    check("mrst_post_drop", drop_valid, 0);
    run_basic("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
